// File: rtl/multiport_latency_memory.sv
// N-port behavioural memory with fixed per-request access latency and per-port handshakes.
// Optional MEM_CONFLICT_STALL_EN: serialise same-word completions that involve a write instead of merging.

module mlm_port #(
    parameter int DW      = 16,
    parameter int BW      = 2,
    parameter int IW      = 12,
    parameter int LATENCY = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          read_i,
    input  logic          write_i,
    input  logic [BW-1:0] wmask_i,
    input  logic [IW-1:0] idx_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          stall_i,
    output logic          cand_o,
    output logic          wr_o,
    output logic [IW-1:0] idx_o,
    output logic [BW-1:0] mask_o,
    output logic [DW-1:0] data_o
);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    typedef struct packed {
        logic          wr;
        logic [IW-1:0] idx;
        logic [BW-1:0] mask;
        logic [DW-1:0] data;
    } req_t;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    req_t          req_q, req_d;
    logic          req;

    assign req = read_i | write_i;

    // Candidate for completion; the top may still hold it off for a conflict.
    assign cand_o = (state_q == BUSY) && req && (cnt_q == '0);
    assign wr_o   = req_q.wr;
    assign idx_o  = req_q.idx;
    assign mask_o = req_q.mask;
    assign data_o = req_q.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = CW'(LATENCY - 1);
                    req_d   = '{wr: write_i, idx: idx_i, mask: wmask_i, data: wdata_i};
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!stall_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

module multiport_latency_memory #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4096,
    parameter int LATENCY    = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NUM_PORTS-1:0]                        read,
    input  logic [NUM_PORTS-1:0]                        write,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0]      wmask,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]        address,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        wdata,
    output logic [NUM_PORTS-1:0]                        resp,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]        rdata
);
    localparam int BW  = DATA_WIDTH / 8;
    localparam int OFF = $clog2(BW);
    localparam int IW  = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]              mem [DEPTH];
    logic [NUM_PORTS-1:0]               cand, stall, pwr;
    logic [NUM_PORTS-1:0][IW-1:0]       pidx;
    logic [NUM_PORTS-1:0][BW-1:0]       pmask;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] pdata;
    logic                               unused_addr;

    assign unused_addr = ^address;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        mlm_port #(.DW(DATA_WIDTH), .BW(BW), .IW(IW), .LATENCY(LATENCY)) u_port (
            .clk    (clk),
            .rst_n  (rst_n),
            .read_i (read[p]),
            .write_i(write[p]),
            .wmask_i(wmask[p]),
            .idx_i  (address[p][OFF +: IW]),
            .wdata_i(wdata[p]),
            .stall_i(stall[p]),
            .cand_o (cand[p]),
            .wr_o   (pwr[p]),
            .idx_o  (pidx[p]),
            .mask_o (pmask[p]),
            .data_o (pdata[p])
        );
    end

`ifdef MEM_CONFLICT_STALL_EN
    logic [NUM_PORTS-1:0] conf;

    // A port in a write-involving same-word clash waits unless it is the lowest clashing port on that word.
    always_comb begin
        conf  = '0;
        stall = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int q = 0; q < NUM_PORTS; q++) begin
                if (q != p && cand[p] && cand[q] && pidx[p] == pidx[q] && (pwr[p] || pwr[q]))
                    conf[p] = 1'b1;
            end
        end
        for (int p = 1; p < NUM_PORTS; p++) begin
            for (int q = 0; q < p; q++) begin
                if (conf[p] && conf[q] && pidx[p] == pidx[q])
                    stall[p] = 1'b1;
            end
        end
    end
`else
    assign stall = '0;
`endif

    assign resp = cand & ~stall;

    // Descending order so the lowest-numbered port's bytes land last and win.
    always_ff @(posedge clk) begin
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (resp[p] && pwr[p]) begin
                for (int b = 0; b < BW; b++) begin
                    if (pmask[p][b])
                        mem[pidx[p]][b*8 +: 8] <= pdata[p][b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (resp[p] && !pwr[p])
                rdata[p] = mem[pidx[p]];
        end
    end
endmodule

// File: tb/tb_multiport_latency_memory.sv
// Directed bench for multiport_latency_memory (2 ports, 16-bit, LATENCY 3) with a transaction-level model.
module tb_multiport_latency_memory;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        rd = '0, wr = '0;
    logic [1:0][1:0]   wm = '0;
    logic [1:0][15:0]  ad = '0, wd = '0;
    logic [1:0]        resp;
    logic [1:0][15:0]  rdata;

    int total = 0;
    int bad   = 0;

    multiport_latency_memory #(
        .NUM_PORTS(2), .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(4096), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .read(rd), .write(wr), .wmask(wm),
        .address(ad), .wdata(wd), .resp(resp), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // Model: one outstanding transaction per port, completing LAT cycles after acceptance.
    logic [15:0] mm [4096];
    logic [1:0]  m_act = '0;
    int          m_due [2];
    int          m_idx [2];
    logic        m_wr  [2];
    logic [1:0]  m_mask[2];
    logic [15:0] m_data[2];
    int          cyc = 0;

    always @(negedge clk) begin
        logic [1:0]       req, cand, stl, er;
        logic [1:0][15:0] ed;
        logic [15:0]      t;
        logic             win;
        if (!rst_n) begin
            chk("rst_resp", 32'(resp), 32'h0);
            chk("rst_rdata", 32'(rdata), 32'h0);
            m_act = '0;
        end else begin
            req = rd | wr;
            for (int p = 0; p < 2; p++)
                cand[p] = m_act[p] && (cyc >= m_due[p]) && req[p];
            stl = '0;
`ifdef MEM_CONFLICT_STALL_EN
            if (cand[0] && cand[1] && m_idx[0] == m_idx[1] && (m_wr[0] || m_wr[1]))
                stl[1] = 1'b1;
`endif
            er = cand & ~stl;
            for (int p = 0; p < 2; p++) begin
                ed[p] = (er[p] && !m_wr[p]) ? mm[m_idx[p]] : 16'h0;
                chk($sformatf("resp%0d@%0d", p, cyc), 32'(resp[p]), 32'(er[p]));
                chk($sformatf("rdata%0d@%0d", p, cyc), 32'(rdata[p]), 32'(ed[p]));
            end
            for (int p = 0; p < 2; p++) begin
                if (er[p] && m_wr[p]) begin
                    t = mm[m_idx[p]];
                    for (int b = 0; b < 2; b++) begin
                        win = m_mask[p][b];
                        for (int q = 0; q < p; q++)
                            if (er[q] && m_wr[q] && m_idx[q] == m_idx[p] && m_mask[q][b]) win = 1'b0;
                        if (win) t[b*8 +: 8] = m_data[p][b*8 +: 8];
                    end
                    mm[m_idx[p]] = t;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (m_act[p]) begin
                    if (!req[p] || er[p]) m_act[p] = 1'b0;
                end else if (req[p]) begin
                    m_act[p]  = 1'b1;
                    m_due[p]  = cyc + LAT;
                    m_idx[p]  = (int'(ad[p]) >> 1) % 4096;
                    m_wr[p]   = wr[p];
                    m_mask[p] = wm[p];
                    m_data[p] = wd[p];
                end
            end
        end
        cyc++;
    end

    task automatic drv(input int p, input logic r, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] m);
        rd[p] = r; wr[p] = w; ad[p] = a; wd[p] = d; wm[p] = m;
    endtask

    // Called at posedge+1 (cycle 0); reports the cycle each enabled port responded in.
    task automatic go(input logic [1:0] en, output int l0, output int l1,
                      output logic [15:0] d0, output logic [15:0] d1);
        logic [1:0] got = '0;
        l0 = -1; l1 = -1; d0 = '0; d1 = '0;
        for (int k = 0; k < 20 && (got & en) != en; k++) begin
            @(negedge clk);
            if (en[0] && !got[0] && resp[0]) begin got[0] = 1'b1; l0 = k; d0 = rdata[0]; end
            if (en[1] && !got[1] && resp[1]) begin got[1] = 1'b1; l1 = k; d1 = rdata[1]; end
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++)
                if (got[p]) begin rd[p] = 1'b0; wr[p] = 1'b0; end
        end
        if ((got & en) != en) begin
            total++; bad++;
            $display("FAIL timeout: got %b want %b", got, en);
        end
    endtask

    initial begin
        int l0, l1;
        logic [15:0] d0, d1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_resp", 32'(resp), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // 1: write then read back
        drv(0, 0, 1, 16'h0010, 16'hBEEF, 2'b11);
        go(2'b01, l0, l1, d0, d1);
        chk("t1_wlat", l0, 3);
        drv(0, 1, 0, 16'h0010, 16'h0000, 2'b00);
        go(2'b01, l0, l1, d0, d1);
        chk("t1_rlat", l0, 3);
        chk("t1_rdata", 32'(d0), 32'hBEEF);

        // 2: partial byte write
        drv(1, 0, 1, 16'h0020, 16'hAAAA, 2'b11);
        go(2'b10, l0, l1, d0, d1);
        drv(1, 0, 1, 16'h0020, 16'h1234, 2'b01);
        go(2'b10, l0, l1, d0, d1);
        drv(0, 1, 0, 16'h0020, 16'h0000, 2'b00);
        go(2'b01, l0, l1, d0, d1);
        chk("t2_rdata", 32'(d0), 32'hAA34);

        // 3: same-word double write
        drv(0, 0, 1, 16'h0030, 16'h5555, 2'b11);
        drv(1, 0, 1, 16'h0030, 16'h6666, 2'b11);
        go(2'b11, l0, l1, d0, d1);
        chk("t3_lat0", l0, 3);
`ifdef MEM_CONFLICT_STALL_EN
        chk("t3_lat1", l1, 4);
`else
        chk("t3_lat1", l1, 3);
`endif
        drv(0, 1, 0, 16'h0030, 16'h0000, 2'b00);
        go(2'b01, l0, l1, d0, d1);
`ifdef MEM_CONFLICT_STALL_EN
        chk("t3_rdata", 32'(d0), 32'h6666);
`else
        chk("t3_rdata", 32'(d0), 32'h5555);
`endif

        // 4: write and read of the same word together
        drv(0, 0, 1, 16'h0040, 16'h0000, 2'b11);
        go(2'b01, l0, l1, d0, d1);
        drv(0, 0, 1, 16'h0040, 16'h0F0F, 2'b11);
        drv(1, 1, 0, 16'h0040, 16'h0000, 2'b00);
        go(2'b11, l0, l1, d0, d1);
`ifdef MEM_CONFLICT_STALL_EN
        chk("t4_lat1", l1, 4);
        chk("t4_rdata", 32'(d1), 32'h0F0F);
`else
        chk("t4_lat1", l1, 3);
        chk("t4_rdata", 32'(d1), 32'h0000);
`endif

        // 5: aborted write, then read through an aliasing address
        drv(0, 0, 1, 16'h0050, 16'h1111, 2'b11);
        go(2'b01, l0, l1, d0, d1);
        drv(0, 0, 1, 16'h0050, 16'h7777, 2'b11);
        @(posedge clk); #1;
        drv(0, 0, 0, 16'h0050, 16'h7777, 2'b11);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_noresp", 32'(resp), 32'h0);
        end
        @(posedge clk); #1;
        drv(1, 1, 0, 16'h2050, 16'h0000, 2'b00);
        go(2'b10, l0, l1, d0, d1);
        chk("t5_lat", l1, 3);
        chk("t5_rdata", 32'(d1), 32'h1111);

        // 6: reset while busy discards the write
        drv(1, 0, 1, 16'h0060, 16'h3333, 2'b11);
        go(2'b10, l0, l1, d0, d1);
        drv(1, 0, 1, 16'h0060, 16'h9999, 2'b11);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drv(1, 0, 0, 16'h0060, 16'h9999, 2'b11);
        #1;
        chk("t6_rst_resp", 32'(resp), 32'h0);
        chk("t6_rst_rdata", 32'(rdata), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        drv(1, 1, 0, 16'h0060, 16'h0000, 2'b00);
        go(2'b10, l0, l1, d0, d1);
        chk("t6_lat", l1, 3);
        chk("t6_rdata", 32'(d1), 32'h3333);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
